// File: rtl/shift_pkg.sv
// Shared types and constants for the shift sequencer.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

endpackage

// File: rtl/shift_seq_fsm.sv
// Sequencing control for the shift sequencer.
// Holds the state, the down-counter and the clamp, and strobes the datapath.
module shift_seq_fsm
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] amount,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic          load,
    output logic          shift_en
);

    localparam logic [AW-1:0] MAX_CNT = AW'(WIDTH);

    seq_state_t    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] clamped_s;

    // Distances beyond the operand width behave exactly like a full-width shift.
    assign clamped_s = (amount > MAX_CNT) ? MAX_CNT : amount;

    // Next-state, counter and strobe logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        load     = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = clamped_s;
                    state_d = (clamped_s == {AW{1'b0}}) ? DONE : SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                cnt_d    = cnt_q - AW'(1);
                if (cnt_q == AW'(1)) begin
                    state_d = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {AW{1'b0}};
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= {AW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SHIFT) || (state_q == DONE);
    assign done  = (state_q == DONE);

endmodule

// File: rtl/shift_sequencer.sv
// Multi-bit right shifter that performs one single-bit shift per clock.
// Holds the working register and fill mux; sequencing lives in shift_seq_fsm.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    amount,
    input  logic             mode,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] work_q, work_d;
    logic             mode_q, mode_d;
    logic             load_s;
    logic             shift_en_s;
    logic             fill_s;

    shift_seq_fsm #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .amount   (amount),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .load     (load_s),
        .shift_en (shift_en_s)
    );

    assign fill_s = (mode_q == MODE_ARITH) ? work_q[WIDTH-1] : 1'b0;

    // Working register and mode: load on accept, shift on each strobe, else hold.
    always_comb begin
        work_d = work_q;
        mode_d = mode_q;
        if (load_s) begin
            work_d = data_in;
            mode_d = mode;
        end else if (shift_en_s) begin
            work_d = {fill_s, work_q[WIDTH-1:1]};
        end else begin
            work_d = work_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            work_q <= {WIDTH{1'b0}};
            mode_q <= 1'b0;
        end else begin
            work_q <= work_d;
            mode_q <= mode_d;
        end
    end

    assign result = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int WIDTH = 16;
    localparam int AW    = 5;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [AW-1:0]    amount;
    logic             mode;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    int total;
    int bad;

    shift_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .amount  (amount),
        .mode    (mode),
        .ready   (ready),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [4:0]  a;
        logic        m;
        logic [15:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input int a, input logic m);
        int n;
        logic signed [15:0] s;
        n = (a > WIDTH) ? WIDTH : a;
        s = d;
        if (m) return d >> n;
        else   return s >>> n;
    endfunction

    // Starts an operation at a negedge in IDLE; returns result and done latency
    // (cycles after the accepting edge), ending at the first IDLE negedge after done.
    task automatic run_op(input logic [15:0] d, input logic [4:0] a, input logic m,
                          output logic [15:0] res, output int lat, output int bcnt);
        data_in = d; amount = a; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data_in = 16'($urandom); amount = 5'($urandom); mode = 1'($urandom);
        lat = 0; bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        res = result;
        @(negedge clk);
    endtask

    vec_t        vecs[8];
    logic [15:0] res;
    int          lat;
    int          bcnt;
    int          dcnt;
    logic [15:0] rd;
    logic [4:0]  ra;
    logic        rm;
    int          rn;

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; data_in = 16'h0; amount = 5'd0; mode = 1'b0;

        vecs[0] = '{16'h8000, 5'd4,  1'b0, 16'hF800, 5};
        vecs[1] = '{16'h8000, 5'd4,  1'b1, 16'h0800, 5};
        vecs[2] = '{16'h1234, 5'd0,  1'b0, 16'h1234, 1};
        vecs[3] = '{16'h8001, 5'd20, 1'b0, 16'hFFFF, 17};
        vecs[4] = '{16'h8001, 5'd20, 1'b1, 16'h0000, 17};
        vecs[5] = '{16'h7FFF, 5'd16, 1'b0, 16'h0000, 17};
        vecs[6] = '{16'h8000, 5'd31, 1'b0, 16'hFFFF, 17};
        vecs[7] = '{16'h00F0, 5'd1,  1'b1, 16'h0078, 2};

        // Reset state, including a start held during reset.
        @(negedge clk);
        start = 1'b1; data_in = 16'hBEEF; amount = 5'd3;
        @(negedge clk);
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", {16'd0, result}, 32'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {31'd0, ready}, 32'd1);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].m, res, lat, bcnt);
            check($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp_res});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat);
            check($sformatf("vec%0d_hold", i), {16'd0, result}, {16'd0, vecs[i].exp_res});
            check($sformatf("vec%0d_ready", i), {31'd0, ready}, 32'd1);
        end

        // start pulses during SHIFT and DONE are ignored.
        data_in = 16'h8000; amount = 5'd4; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; dcnt = 0;
        for (int c = 1; c <= 12; c++) begin
            if (done) dcnt++;
            if (c == 2 || c == 5) begin
                start = 1'b1; data_in = 16'hAAAA; amount = 5'd1; mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (c == 5) check("ignore_done_cycle", {31'd0, done}, 32'd1);
            @(negedge clk);
        end
        check("ignore_done_count", dcnt, 1);
        check("ignore_result", {16'd0, result}, 32'h0000F800);

        // Reset in the middle of a shift discards the operation.
        data_in = 16'hFFFF; amount = 5'd8; mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset_ready", {31'd0, ready}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_result", {16'd0, result}, 32'd0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        check("midreset_no_done", dcnt, 0);
        run_op(16'h00F0, 5'd4, 1'b1, res, lat, bcnt);
        check("post_reset_result", {16'd0, res}, 32'h0000000F);
        check("post_reset_latency", lat, 5);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rd = 16'($urandom);
            ra = 5'($urandom_range(0, 24));
            rm = 1'($urandom);
            rn = (ra > WIDTH) ? WIDTH : ra;
            run_op(rd, ra, rm, res, lat, bcnt);
            check($sformatf("rand%0d_result", i), {16'd0, res}, {16'd0, model(rd, ra, rm)});
            check($sformatf("rand%0d_latency", i), lat, rn + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
